// File: rtl/alu_1b_pkg.sv
// ============================================================================
// alu_1b_pkg : op encoding and reset constants for the 1-bit ALU slice
// Revision   : 1.0
// ============================================================================
`default_nettype none

package alu_1b_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam logic X_RST    = 1'b0;
  localparam logic COUT_RST = 1'b0;
  localparam logic OVF_RST  = 1'b0;

endpackage : alu_1b_pkg

`default_nettype wire

// File: rtl/alu_1b_if.sv
// ============================================================================
// alu_1b_if : operand/control/result bundle of one ALU slice
//             (ovf member present when ALU_1B_OVF_EN is defined)
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface alu_1b_if;

  logic a;
  logic b;
  logic ainvert;
  logic binvert;
  logic cin;
  logic s1;
  logic s0;
  logic x;
  logic cout;
`ifdef ALU_1B_OVF_EN
  logic ovf;

  modport master (
    output a, b, ainvert, binvert, cin, s1, s0,
    input  x, cout, ovf
  );

  modport slave (
    input  a, b, ainvert, binvert, cin, s1, s0,
    output x, cout, ovf
  );
`else
  modport master (
    output a, b, ainvert, binvert, cin, s1, s0,
    input  x, cout
  );

  modport slave (
    input  a, b, ainvert, binvert, cin, s1, s0,
    output x, cout
  );
`endif

endinterface : alu_1b_if

`default_nettype wire

// File: rtl/alu_1b_full_adder_1b.sv
// ============================================================================
// full_adder_1b : combinational 1-bit full adder
// Revision      : 1.0
// ============================================================================
`default_nettype none

module full_adder_1b (
  input  wire logic ae,
  input  wire logic be,
  input  wire logic cin,
  output logic      sum,
  output logic      cout
);

  assign sum  = ae ^ be ^ cin;
  assign cout = (ae & be) | (ae & cin) | (be & cin);

endmodule : full_adder_1b

`default_nettype wire

// File: rtl/alu_1b.sv
// ============================================================================
// alu_1b : registered 1-bit ALU slice (invert, then AND/OR/ADD/XOR)
//          optional registered ovf output under ALU_1B_OVF_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_1b
  import alu_1b_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  alu_1b_if.slave   bus
);

  logic    ae;
  logic    be;
  logic    fa_sum;
  logic    fa_cout;
  alu_op_e op;
  logic    x_d;
  logic    x_q;
  logic    cout_d;
  logic    cout_q;

  assign ae = bus.a ^ bus.ainvert;
  assign be = bus.b ^ bus.binvert;
  assign op = alu_op_e'({bus.s1, bus.s0});

  // Adder always evaluated so cout is meaningful for every op
  full_adder_1b u_fa (
    .ae   (ae),
    .be   (be),
    .cin  (bus.cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    x_d    = X_RST;
    cout_d = fa_cout;
    unique case (op)
      OP_AND:  x_d = ae & be;
      OP_OR:   x_d = ae | be;
      OP_ADD:  x_d = fa_sum;
      OP_XOR:  x_d = ae ^ be;
      default: x_d = X_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= X_RST;
      cout_q <= COUT_RST;
    end else begin
      x_q    <= x_d;
      cout_q <= cout_d;
    end
  end

  assign bus.x    = x_q;
  assign bus.cout = cout_q;

`ifdef ALU_1B_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = bus.cin ^ cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= OVF_RST;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule : alu_1b

`default_nettype wire

// File: tb/tb_alu_1b.sv
// ============================================================================
// tb_alu_1b : directed table, reset sequences and random vs. arithmetic model
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_alu_1b;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_1b_if bus ();

  alu_1b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       ai;
    logic       bi;
    logic       cin;
    logic [1:0] op;
    logic       ex;
    logic       ec;
  } vec_t;

  vec_t tbl [15];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic ai, input logic bi,
                       input logic cin, input logic [1:0] op);
    bus.a       = a;
    bus.b       = b;
    bus.ainvert = ai;
    bus.binvert = bi;
    bus.cin     = cin;
    bus.s1      = op[1];
    bus.s0      = op[0];
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: integer sum of conditioned operands and carry
  function automatic logic [2:0] ref_model(input logic a, input logic b, input logic ai,
                                           input logic bi, input logic cin,
                                           input logic [1:0] op);
    int ae, be, s, xr, cr, ovr;
    ae = (a != ai) ? 1 : 0;
    be = (b != bi) ? 1 : 0;
    s  = ae + be + int'(cin);
    case (op)
      2'd0:    xr = ae * be;
      2'd1:    xr = (ae + be > 0) ? 1 : 0;
      2'd2:    xr = s % 2;
      default: xr = (ae + be) % 2;
    endcase
    cr  = s / 2;
    ovr = (int'(cin) != cr) ? 1 : 0;
    return {xr[0], cr[0], ovr[0]};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [2:0] r;
    logic [1:0] op;
    logic a, b, ai, bi, c;
    checks = 0;
    errors = 0;

    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1}
    };

    // Reset asserted with arbitrary inputs, checked before any clock edge
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check1("rst_x_async", bus.x, 1'b0);
    check1("rst_cout_async", bus.cout, 1'b0);
    step;
    step;
    check1("rst_x_held", bus.x, 1'b0);
    check1("rst_cout_held", bus.cout, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    step;
    check1("post_rst_x", bus.x, 1'b1);
    check1("post_rst_cout", bus.cout, 1'b1);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ai, tbl[i].bi, tbl[i].cin, tbl[i].op);
      step;
      check1($sformatf("tbl%0d_x", i), bus.x, tbl[i].ex);
      check1($sformatf("tbl%0d_cout", i), bus.cout, tbl[i].ec);
    end

    // Reset between edges while ADD 1+1+1 is pending
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    step;
    check1("mid_pre_x", bus.x, 1'b1);
    check1("mid_pre_cout", bus.cout, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_x", bus.x, 1'b0);
    check1("mid_rst_cout", bus.cout, 1'b0);
    step;
    check1("mid_hold_x", bus.x, 1'b0);
    check1("mid_hold_cout", bus.cout, 1'b0);
    rst_n = 1'b1;
    #2;
    check1("mid_rel_x", bus.x, 1'b0);
    check1("mid_rel_cout", bus.cout, 1'b0);
    step;
    check1("mid_cap_x", bus.x, 1'b1);
    check1("mid_cap_cout", bus.cout, 1'b1);

`ifdef ALU_1B_OVF_EN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    step;
    check1("ovf_cin1_a0b0", bus.ovf, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
    step;
    check1("ovf_cin1_a1b1", bus.ovf, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      ai = 1'($urandom_range(0, 1));
      bi = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      r  = ref_model(a, b, ai, bi, c, op);
      drive(a, b, ai, bi, c, op);
      step;
      check1($sformatf("rnd%0d_x", n), bus.x, r[2]);
      check1($sformatf("rnd%0d_cout", n), bus.cout, r[1]);
`ifdef ALU_1B_OVF_EN
      check1($sformatf("rnd%0d_ovf", n), bus.ovf, r[0]);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_1b

`default_nettype wire
